// File: rtl/game_pkg.sv
// Shared definitions for the game input stage: per-button FSM states,
// button index constants and the counter sizing helper.
package game_pkg;

  typedef enum logic [4:0] {
    ST_INI  = 5'b00001,
    ST_W84  = 5'b00010,
    ST_SCEN = 5'b00100,
    ST_WS   = 5'b01000,
    ST_WR   = 5'b10000
  } btn_state_e;

  localparam int BTN_SELECT = 0;
  localparam int BTN_QUIT   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;

  // One counter serves debounce and auto-repeat, so it must hold the largest limit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: 2-flop synchroniser, shared debounce/repeat counter and Moore FSM.
// Handshake-free: o_scen/o_mcen are single-cycle enables, o_dpb is a level.
module btn_debounce_fsm
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_btn_raw,
  output logic o_dpb,
  output logic o_scen,
  output logic o_mcen
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic             r_s1;
  logic             r_s2;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;

  btn_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_first_nxt;
  logic             w_rep_hit;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= ST_INI;
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else begin
      r_s1    <= i_btn_raw;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
    end
  end

  // First repeat waits the long delay; later ones use the shorter rate.
  assign w_rep_hit = (r_state == ST_WS) &&
                     (r_first ? (r_cnt == DELAY_LAST) : (r_cnt == RATE_LAST));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_first;
    case (r_state)
      ST_INI: begin
        w_cnt_nxt = '0;
        if (r_s2) w_state_nxt = ST_W84;
      end
      ST_W84: begin
        if (!r_s2) begin
          w_state_nxt = ST_INI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = ST_SCEN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_SCEN: begin
        w_state_nxt = ST_WS;
        w_cnt_nxt   = '0;
        w_first_nxt = 1'b1;
      end
      ST_WS: begin
        if (!r_s2) begin
          w_state_nxt = ST_WR;
          w_cnt_nxt   = '0;
        end else if (w_rep_hit) begin
          w_cnt_nxt   = '0;
          w_first_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_WR: begin
        // Release bounce returns to WS without a new Scen; repeat timing restarts.
        if (r_s2) begin
          w_state_nxt = ST_WS;
          w_cnt_nxt   = '0;
          w_first_nxt = 1'b1;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = ST_INI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_INI;
        w_cnt_nxt   = '0;
        w_first_nxt = 1'b0;
      end
    endcase
  end

  assign o_scen = (r_state == ST_SCEN);
  assign o_mcen = o_scen | w_rep_hit;
  assign o_dpb  = (r_state == ST_SCEN) || (r_state == ST_WS) || (r_state == ST_WR);

endmodule

// File: rtl/game_button_conditioner.sv
// Input stage for the game FSM: one debounce FSM per board button, plus the
// AnyScen OR that qualifies the game's CEN.
module game_button_conditioner
  import game_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] BtnRaw,
  output logic [N_BTN-1:0] Dpb,
  output logic [N_BTN-1:0] Scen,
  output logic [N_BTN-1:0] Mcen,
  output logic             AnyScen
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_btn (
      .Clk       (Clk),
      .Reset     (Reset),
      .i_btn_raw (BtnRaw[g]),
      .o_dpb     (Dpb[g]),
      .o_scen    (Scen[g]),
      .o_mcen    (Mcen[g])
    );
  end

  assign AnyScen = |Scen;

endmodule

// File: tb/tb_game_button_conditioner.sv
// Directed bench for game_button_conditioner with small debounce/repeat limits.
// Expected pulse events are queued as stimulus is driven and popped by a monitor.
module tb_game_button_conditioner;

  localparam int N_BTN = 4;
  localparam int W     = 41;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [N_BTN-1:0] BtnRaw;
  logic [N_BTN-1:0] Dpb;
  logic [N_BTN-1:0] Scen;
  logic [N_BTN-1:0] Mcen;
  logic             AnyScen;

  int cyc     = 0;
  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_obs;

  game_button_conditioner #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_RATE     (4)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .BtnRaw  (BtnRaw),
    .Dpb     (Dpb),
    .Scen    (Scen),
    .Mcen    (Mcen),
    .AnyScen (AnyScen)
  );

  // Clock / cycle index: cyc equals the number of the most recent rising edge.
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [N_BTN-1:0] obs, input logic [N_BTN-1:0] exp);
    check(tag, W'(obs), W'(exp));
  endtask

  function automatic logic [W-1:0] ev(input int c, input logic [3:0] s,
                                      input logic [3:0] m, input logic a);
    return {32'(c), s, m, a};
  endfunction

  // Scen at cycle s, then repeats at s+8, s+12, ... while still held at cycle last.
  task automatic push_press(input int s, input int last, input logic [3:0] mask);
    exp_q.push_back(ev(s, mask, mask, 1'b1));
    for (int t = s + 8; t <= last; t += 4) exp_q.push_back(ev(t, 4'b0, mask, 1'b0));
  endtask

  // Returns #1 after rising edge c; inputs set here are sampled at edge c+1.
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every observed pulse must match the next queued event.
  always @(negedge Clk) begin
    if ((Scen != '0) || (Mcen != '0) || AnyScen) begin
      mon_obs = ev(cyc, Scen, Mcen, AnyScen);
      if (exp_q.size() == 0) check("unexpected_pulse", mon_obs, '0);
      else                   check("pulse", mon_obs, exp_q.pop_front());
    end
  end

  initial begin
    Reset  = 1'b1;
    BtnRaw = '0;

    at(1);
    chk4("reset_dpb", Dpb, 4'b0);
    chk4("reset_scen", Scen, 4'b0);
    chk4("reset_mcen", Mcen, 4'b0);
    check("reset_any", W'(AnyScen), '0);
    at(2);
    Reset = 1'b0;

    // Clean press bit0 sampled at edge 10, released at edge 40.
    push_press(16, 40, 4'b0001);
    at(9);  BtnRaw[0] = 1'b1;
    at(15); chk4("clean_dpb_before", Dpb, 4'b0000);
    at(16); chk4("clean_dpb_scen", Dpb, 4'b0001);
    at(39); BtnRaw[0] = 1'b0;
    at(45); chk4("clean_dpb_wr_end", Dpb, 4'b0001);
    at(46); chk4("clean_dpb_fall", Dpb, 4'b0000);

    // Press bounce on bit2: samples 1,0,1,0 at edges 50..53, stable 1 from 54.
    push_press(60, 66, 4'b0100);
    at(49); BtnRaw[2] = 1'b1;
    at(50); BtnRaw[2] = 1'b0;
    at(51); BtnRaw[2] = 1'b1;
    at(52); BtnRaw[2] = 1'b0;
    at(53); BtnRaw[2] = 1'b1;
    at(59); chk4("bounce_dpb_before", Dpb, 4'b0000);
    at(65); BtnRaw[2] = 1'b0;
    at(71); chk4("bounce_dpb_held", Dpb, 4'b0100);
    at(72); chk4("bounce_dpb_fall", Dpb, 4'b0000);

    // Long hold on bit3: auto-repeat at +8, +12, +16, ...
    push_press(86, 110, 4'b1000);
    at(79);  BtnRaw[3] = 1'b1;
    at(109); BtnRaw[3] = 1'b0;
    at(116); chk4("hold_dpb_fall", Dpb, 4'b0000);

    // Release bounce on bit0: raw back to 1 for one sample during WR.
    push_press(126, 132, 4'b0001);
    at(119); BtnRaw[0] = 1'b1;
    at(131); BtnRaw[0] = 1'b0;
    at(133); BtnRaw[0] = 1'b1;
    at(134); BtnRaw[0] = 1'b0;
    at(137); chk4("relbounce_dpb_137", Dpb, 4'b0001);
    at(140); chk4("relbounce_dpb_140", Dpb, 4'b0001);

    // Bit3 held into a reset; bit1 reset two cycles into its debounce.
    push_press(147, 153, 4'b1000);
    BtnRaw[3] = 1'b1;
    at(141); chk4("relbounce_dpb_fall", Dpb, 4'b0000);
    at(149); BtnRaw[1] = 1'b1;
    at(152); chk4("prereset_dpb", Dpb, 4'b1000);
    at(153);
    Reset     = 1'b1;
    BtnRaw[3] = 1'b0;
    #1;
    chk4("midreset_dpb", Dpb, 4'b0000);
    chk4("midreset_scen", Scen, 4'b0000);
    chk4("midreset_mcen", Mcen, 4'b0000);
    check("midreset_any", W'(AnyScen), '0);
    push_press(162, 166, 4'b0010);
    at(155); Reset = 1'b0;
    at(161); chk4("postreset_dpb_before", Dpb, 4'b0000);
    at(162); chk4("postreset_dpb_scen", Dpb, 4'b0010);
    at(165); BtnRaw[1] = 1'b0;
    at(172); chk4("postreset_dpb_fall", Dpb, 4'b0000);

    // Bits 0 and 1 pressed on the same edge.
    push_press(186, 190, 4'b0011);
    at(179); BtnRaw[1:0] = 2'b11;
    at(185); chk4("dual_dpb_before", Dpb, 4'b0000);
    at(186); chk4("dual_dpb_scen", Dpb, 4'b0011);
    at(189); BtnRaw[1:0] = 2'b00;

    at(200);
    chk4("final_dpb", Dpb, 4'b0000);
    check("queue_empty", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
